// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the pipeline MEM
// stage and a DMA/loader requester. The CPU has priority and is served
// combinationally. DMA requests are granted as fixed-length bursts with
// address auto-increment. cpu_stall is raised while a burst blocks the CPU.
// Optional feature macro: DMEM_ARB_STARVE_EN adds a starvation counter. The
// counter forces a DMA grant after STARVE_LIMIT consecutive denied cycles.
module dmem_arbiter #(
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    parameter int MAX_BURST    = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [3:0]        dma_len,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic              dma_done,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int LEN_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arbState_t;

    arbState_t         state;
    logic              burstWe;
    logic [ADDR_W-1:0] burstAddr;
    logic [LEN_W-1:0]  beatsLeft;
    logic [LEN_W-1:0]  effLen;
    logic              cpuAccess;
    logic              grant;
    logic              starveHit;

    assign cpuAccess = cpu_rd | cpu_wr;
    assign grant     = (state == IDLE) && dma_req && (!cpuAccess || starveHit);

    // Effective burst length: zero means one beat, oversize requests clamp.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        effLen = LEN_W'(dma_len);
        if (dma_len == 4'd0) begin
            effLen = LEN_W'(1);
        end else if (32'(dma_len) > MAX_BURST) begin
            effLen = LEN_W'(MAX_BURST);
        end
    end

`ifdef DMEM_ARB_STARVE_EN
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    logic [WAIT_W-1:0] waitCnt;

    // Count consecutive denied request cycles in IDLE, saturating at the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            waitCnt <= '0;
        end else if (!dma_req || grant) begin
            waitCnt <= '0;
        end else if (state == IDLE && waitCnt != WAIT_W'(STARVE_LIMIT)) begin
            waitCnt <= waitCnt + WAIT_W'(1);
        end
    end

    assign starveHit = (waitCnt == WAIT_W'(STARVE_LIMIT));
`else
    // No counter: strict CPU priority, starvation relief permanently off.
    assign starveHit = 1'b0 & (STARVE_LIMIT > 0);
`endif

    // Burst FSM: latch the request at grant, step one beat per cycle, pulse done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            burstWe    <= 1'b0;
            burstAddr  <= '0;
            beatsLeft  <= '0;
            dma_rdata  <= '0;
            dma_rvalid <= 1'b0;
            dma_done   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            dma_done   <= 1'b0;
            dma_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        state     <= BURST;
                        burstWe   <= dma_we;
                        burstAddr <= dma_addr;
                        beatsLeft <= effLen;
                    end
                end
                BURST: begin
                    burstAddr <= burstAddr + ADDR_W'(1);
                    beatsLeft <= beatsLeft - LEN_W'(1);
                    if (!burstWe) begin
                        dma_rdata  <= mem_rdata;
                        dma_rvalid <= 1'b1;
                    end
                    if (beatsLeft == LEN_W'(1)) begin
                        state    <= IDLE;
                        dma_done <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Memory port steering and handshake outputs; held at zero while in reset.
    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_stall = 1'b0;
        dma_ack   = 1'b0;
        dma_gnt   = 1'b0;
        if (rst) begin
            if (state == BURST) begin
                mem_rd    = !burstWe;
                mem_wr    = burstWe;
                mem_addr  = burstAddr;
                mem_wdata = burstWe ? dma_wdata : '0;
                cpu_stall = cpuAccess;
                dma_ack   = 1'b1;
            end else begin
                mem_rd    = cpu_rd;
                mem_wr    = cpu_wr;
                mem_addr  = cpuAccess ? cpu_addr : '0;
                mem_wdata = cpu_wr ? cpu_wdata : '0;
                dma_gnt   = grant;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a behavioural data
// memory. IDLE-state steering is table-driven. Bursts, collision,
// starvation, length clamp and async reset are hand-written sequences.
// When compiled with DMEM_ARB_STARVE_EN, the starvation sequence expects a
// forced grant.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [4:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_stall;
    logic        dma_req;
    logic        dma_we;
    logic [4:0]  dma_addr;
    logic [3:0]  dma_len;
    logic [31:0] dma_wdata;
    logic        dma_gnt;
    logic        dma_ack;
    logic [31:0] dma_rdata;
    logic        dma_rvalid;
    logic        dma_done;
    logic        mem_rd;
    logic        mem_wr;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] memArr [32];

    int total = 0;
    int bad   = 0;

    dmem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_rd     (cpu_rd),
        .cpu_wr     (cpu_wr),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_stall  (cpu_stall),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_len    (dma_len),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_ack    (dma_ack),
        .dma_rdata  (dma_rdata),
        .dma_rvalid (dma_rvalid),
        .dma_done   (dma_done),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] preVal(input logic [4:0] a);
        return 32'hC0DE_0000 | {27'b0, a};
    endfunction

    // Behavioural DMem: combinational read, write on the rising edge, preloaded in reset.
    assign mem_rdata = memArr[mem_addr];
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) memArr[i] <= preVal(5'(i));
        end else if (mem_wr) begin
            memArr[mem_addr] <= mem_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        check(name, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic checkAddr(input string name, input logic [4:0] act, input logic [4:0] exp);
        check(name, {27'b0, act}, {27'b0, exp});
    endtask

    task automatic idleInputs();
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        dma_req   = 1'b0;
        dma_we    = 1'b0;
        dma_addr  = '0;
        dma_len   = 4'd1;
        dma_wdata = '0;
    endtask

    // Start a write burst from idle, then count ack cycles until done (bounded).
    task automatic runBurst(input logic [3:0] len, output int beats, output bit finished);
        @(negedge clk);
        dma_req  = 1'b1;
        dma_we   = 1'b1;
        dma_addr = 5'd8;
        dma_len  = len;
        #1;
        checkBit("clamp_gnt", dma_gnt, 1'b1);
        beats    = 0;
        finished = 1'b0;
        for (int k = 0; k < 20 && !finished; k++) begin
            @(negedge clk);
            dma_req = 1'b0;
            #1;
            if (dma_ack) beats++;
            if (dma_done) finished = 1'b1;
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        req;
        logic        eRd;
        logic        eWr;
        logic [4:0]  eAddr;
        logic [31:0] eWdata;
        logic        eGnt;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          beats;
        bit          finished;
        logic [4:0]  a;

        idleInputs();
        rst = 1'b0;

        vecs[0] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0};
        vecs[1] = '{1'b1, 1'b0, 5'd7,  32'h0,        1'b0, 1'b1, 1'b0, 5'd7,  32'h0,        1'b0};
        vecs[2] = '{1'b0, 1'b1, 5'd31, 32'hAABB_CCDD, 1'b0, 1'b0, 1'b1, 5'd31, 32'hAABB_CCDD, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 5'd0,  32'h0,        1'b1};
        vecs[4] = '{1'b1, 1'b0, 5'd2,  32'h0,        1'b1, 1'b1, 1'b0, 5'd2,  32'h0,        1'b0};
        vecs[5] = '{1'b0, 1'b0, 5'd19, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0};

        // Reset state
        #2;
        checkBit("rst_gnt", dma_gnt, 1'b0);
        checkBit("rst_ack", dma_ack, 1'b0);
        checkBit("rst_done", dma_done, 1'b0);
        checkBit("rst_rvalid", dma_rvalid, 1'b0);
        check("rst_rdata", dma_rdata, 32'h0);
        checkBit("rst_stall", cpu_stall, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // IDLE steering table; inputs dropped again before the next rising edge
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cpu_rd    = vecs[i].rd;
            cpu_wr    = vecs[i].wr;
            cpu_addr  = vecs[i].addr;
            cpu_wdata = vecs[i].wdata;
            dma_req   = vecs[i].req;
            #1;
            checkBit($sformatf("vec%0d_rd", i), mem_rd, vecs[i].eRd);
            checkBit($sformatf("vec%0d_wr", i), mem_wr, vecs[i].eWr);
            checkAddr($sformatf("vec%0d_addr", i), mem_addr, vecs[i].eAddr);
            check($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].eWdata);
            checkBit($sformatf("vec%0d_gnt", i), dma_gnt, vecs[i].eGnt);
            checkBit($sformatf("vec%0d_stall", i), cpu_stall, 1'b0);
            checkBit($sformatf("vec%0d_ack", i), dma_ack, 1'b0);
            #1;
            idleInputs();
        end

        // Idle DMA write burst: addr 3, 4 beats
        @(negedge clk);
        dma_req  = 1'b1;
        dma_we   = 1'b1;
        dma_addr = 5'd3;
        dma_len  = 4'd4;
        #1;
        checkBit("wr_gnt", dma_gnt, 1'b1);
        checkBit("wr_ack_t", dma_ack, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            dma_req   = 1'b0;
            dma_addr  = 5'd17;
            dma_we    = 1'b0;
            dma_wdata = 32'h1000 + 32'(i);
            #1;
            checkBit("wr_ack", dma_ack, 1'b1);
            checkBit("wr_memwr", mem_wr, 1'b1);
            checkBit("wr_memrd", mem_rd, 1'b0);
            checkAddr("wr_addr", mem_addr, 5'(3 + i));
            check("wr_wdata", mem_wdata, 32'h1000 + 32'(i));
            checkBit("wr_done_early", dma_done, 1'b0);
            checkBit("wr_gnt_beat", dma_gnt, 1'b0);
        end
        @(negedge clk);
        #1;
        checkBit("wr_done", dma_done, 1'b1);
        checkBit("wr_ack_after", dma_ack, 1'b0);
        checkBit("wr_memwr_after", mem_wr, 1'b0);
        checkAddr("wr_addr_after", mem_addr, 5'd0);
        @(negedge clk);
        #1;
        checkBit("wr_done_pulse", dma_done, 1'b0);
        for (int i = 0; i < 4; i++) check("wr_mem_content", memArr[3 + i], 32'h1000 + 32'(i));

        // Wrap-around read burst: addr 30, 4 beats
        @(negedge clk);
        dma_req  = 1'b1;
        dma_we   = 1'b0;
        dma_addr = 5'd30;
        dma_len  = 4'd4;
        #1;
        checkBit("rd_gnt", dma_gnt, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            dma_req  = 1'b0;
            dma_addr = 5'd0;
            #1;
            a = 5'(30 + i);
            checkAddr("rd_addr", mem_addr, a);
            checkBit("rd_memrd", mem_rd, 1'b1);
            checkBit("rd_ack", dma_ack, 1'b1);
            checkBit("rd_rvalid", dma_rvalid, i > 0);
            if (i > 0) check("rd_rdata", dma_rdata, preVal(5'(a - 5'd1)));
        end
        @(negedge clk);
        #1;
        checkBit("rd_done", dma_done, 1'b1);
        checkBit("rd_rvalid_last", dma_rvalid, 1'b1);
        check("rd_rdata_last", dma_rdata, preVal(5'd1));
        @(negedge clk);
        #1;
        checkBit("rd_rvalid_end", dma_rvalid, 1'b0);

        // CPU collision with a 3-beat write burst
        @(negedge clk);
        dma_req  = 1'b1;
        dma_we   = 1'b1;
        dma_addr = 5'd20;
        dma_len  = 4'd3;
        #1;
        checkBit("col_gnt", dma_gnt, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dma_req   = 1'b0;
            cpu_rd    = 1'b1;
            cpu_addr  = 5'd9;
            dma_wdata = 32'h2000 + 32'(i);
            #1;
            checkBit("col_stall", cpu_stall, 1'b1);
            checkBit("col_memrd", mem_rd, 1'b0);
            checkBit("col_memwr", mem_wr, 1'b1);
            checkAddr("col_addr", mem_addr, 5'(20 + i));
        end
        @(negedge clk);
        #1;
        checkBit("col_stall_end", cpu_stall, 1'b0);
        checkBit("col_cpu_rd", mem_rd, 1'b1);
        checkAddr("col_cpu_addr", mem_addr, 5'd9);
        checkBit("col_done", dma_done, 1'b1);
        @(negedge clk);
        idleInputs();

        // Starvation: CPU writes continuously while DMA requests
`ifdef DMEM_ARB_STARVE_EN
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            cpu_wr    = 1'b1;
            cpu_addr  = 5'd10;
            cpu_wdata = 32'h5555_0000;
            dma_req   = 1'b1;
            dma_we    = 1'b0;
            dma_addr  = 5'd0;
            dma_len   = 4'd1;
            #1;
            checkBit($sformatf("starve_gnt_c%0d", c), dma_gnt, c == 5);
            checkBit("starve_stall_idle", cpu_stall, 1'b0);
            checkBit("starve_cpu_served", mem_wr, 1'b1);
            checkAddr("starve_cpu_addr", mem_addr, 5'd10);
        end
        @(negedge clk);
        dma_req = 1'b0;
        #1;
        checkBit("starve_ack", dma_ack, 1'b1);
        checkBit("starve_stall", cpu_stall, 1'b1);
        checkBit("starve_memrd", mem_rd, 1'b1);
        @(negedge clk);
        #1;
        checkBit("starve_done", dma_done, 1'b1);
        checkBit("starve_stall_end", cpu_stall, 1'b0);
`else
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            cpu_wr    = 1'b1;
            cpu_addr  = 5'd10;
            cpu_wdata = 32'h5555_0000;
            dma_req   = 1'b1;
            #1;
            checkBit($sformatf("nostarve_gnt_c%0d", c), dma_gnt, 1'b0);
            checkBit("nostarve_stall", cpu_stall, 1'b0);
            checkBit("nostarve_cpu_served", mem_wr, 1'b1);
        end
`endif
        @(negedge clk);
        idleInputs();

        // Length clamp
        runBurst(4'd0, beats, finished);
        checkBit("len0_finished", finished, 1'b1);
        check("len0_beats", 32'(beats), 32'd1);
        runBurst(4'd15, beats, finished);
        checkBit("len15_finished", finished, 1'b1);
        check("len15_beats", 32'(beats), 32'd8);
        runBurst(4'd8, beats, finished);
        checkBit("len8_finished", finished, 1'b1);
        check("len8_beats", 32'(beats), 32'd8);

        // Async reset during beat 2 of a write burst
        @(negedge clk);
        dma_req   = 1'b1;
        dma_we    = 1'b1;
        dma_addr  = 5'd12;
        dma_len   = 4'd4;
        dma_wdata = 32'h7777_7777;
        #1;
        checkBit("arst_gnt", dma_gnt, 1'b1);
        @(negedge clk);
        dma_req = 1'b0;
        #1;
        checkBit("arst_beat1", dma_ack, 1'b1);
        @(negedge clk);
        #1;
        checkBit("arst_beat2", dma_ack, 1'b1);
        checkAddr("arst_beat2_addr", mem_addr, 5'd13);
        #1;
        rst = 1'b0;
        #1;
        checkBit("arst_ack", dma_ack, 1'b0);
        checkBit("arst_memwr", mem_wr, 1'b0);
        checkAddr("arst_addr", mem_addr, 5'd0);
        check("arst_wdata", mem_wdata, 32'h0);
        check("arst_rdata", dma_rdata, 32'h0);
        checkBit("arst_rvalid", dma_rvalid, 1'b0);
        checkBit("arst_done", dma_done, 1'b0);
        checkBit("arst_gnt0", dma_gnt, 1'b0);
        checkBit("arst_stall", cpu_stall, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            checkBit("arst_hold_done", dma_done, 1'b0);
            checkBit("arst_hold_ack", dma_ack, 1'b0);
        end
        @(negedge clk);
        rst      = 1'b1;
        cpu_rd   = 1'b1;
        cpu_addr = 5'd4;
        #1;
        checkBit("post_idle_rd", mem_rd, 1'b1);
        checkAddr("post_idle_addr", mem_addr, 5'd4);
        checkBit("post_idle_stall", cpu_stall, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cpu_rd = 1'b0;
            #1;
            checkBit("post_no_ack", dma_ack, 1'b0);
            checkBit("post_no_done", dma_done, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single-port data memory between the pipeline MEM stage (EX/MEM register outputs) and an external DMA/loader requester. CPU accesses have priority and are served combinationally in the cycle presented. DMA requests are granted as fixed-length bursts with address auto-increment. The block raises a stall toward the hazard unit whenever a CPU access is blocked by an active burst.

## Interface
- ADDR_W, 5: DMem word address width; the address wraps modulo 2^ADDR_W.
- DATA_W, 32: data width.
- MAX_BURST, 8: maximum beats per DMA burst.
- STARVE_LIMIT, 4: number of consecutive denied DMA request cycles that forces a grant (used only with the macro).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- cpu_rd  in  1  MEM-stage read (MemRead from EX/MEM).
- cpu_wr  in  1  MEM-stage write (MemWrite from EX/MEM).
- cpu_addr  in  ADDR_W  MEM-stage address.
- cpu_wdata  in  DATA_W  MEM-stage store data.
- cpu_stall  out  1  CPU access present but not served this cycle.
- dma_req  in  1  burst request, level.
- dma_we  in  1  burst direction (1 = write); sampled at grant.
- dma_addr  in  ADDR_W  burst start address; sampled at grant.
- dma_len  in  4  requested beats; sampled at grant.
- dma_wdata  in  DATA_W  write data; sampled in each beat cycle.
- dma_gnt  out  1  one-cycle grant pulse.
- dma_ack  out  1  high in each beat cycle.
- dma_rdata  out  DATA_W  registered read data.
- dma_rvalid  out  1  dma_rdata valid; asserted one cycle after a read beat.
- dma_done  out  1  one-cycle pulse in the cycle after the last beat.
- mem_rd, mem_wr  out  1 each  DMem DMemR / DMemW.
- mem_addr  out  ADDR_W  DMem DataAdr.
- mem_wdata  out  DATA_W  DMem DataIn.
- mem_rdata  in  DATA_W  DMem DataOut; combinational read.

## Operation
- The FSM has two states: IDLE and BURST. Reset state is IDLE.
- **IDLE**
  - The DMem port is driven combinationally from the cpu_* inputs.
  - cpu_stall = 0.
- **Grant condition in IDLE:** dma_req && (!(cpu_rd|cpu_wr) || starve_hit).
  - When the condition holds, dma_gnt pulses.
  - On the same edge, the block latches dma_we, dma_addr and the effective length. Effective length: dma_len = 0 is treated as 1; values above MAX_BURST are clamped to MAX_BURST.
  - The FSM moves to BURST on that edge.
  - A CPU access present in the grant cycle is still served in that cycle.
- **BURST**
  - One beat per cycle.
  - The DMem port is driven from the latched direction and current address, and from dma_wdata for writes.
  - dma_ack = 1 in every beat cycle.
  - The address increments each beat and wraps from 2^ADDR_W-1 to 0.
  - Read beat: mem_rdata is registered into dma_rdata, and dma_rvalid = 1 in the following cycle.
  - cpu_stall = cpu_rd|cpu_wr.
  - dma_req is ignored during a burst.
  - After the last beat the FSM returns to IDLE, and dma_done pulses in that IDLE cycle.
  - If dma_req is still high in that cycle, it is treated as a new request. dma_gnt and dma_done may be asserted together.
- When no access is active in either state, mem_rd = mem_wr = 0, and mem_addr / mem_wdata hold 0.
- **Starvation counter wait_cnt** (width clog2(STARVE_LIMIT+1))
  - Increments in each IDLE cycle with dma_req high and no grant.
  - Saturates at STARVE_LIMIT.
  - Cleared on grant, and cleared when dma_req is low.
  - starve_hit = (wait_cnt == STARVE_LIMIT).
- **Reset asserted mid-burst:** the burst aborts immediately, with no dma_done and no further beats. All outputs return to their reset values asynchronously.

## Timing
- Reset values: all outputs 0, FSM in IDLE, wait_cnt = 0, latched burst registers = 0.
- CPU access latency: 0 cycles when not stalled (combinational pass-through).
- Grant at edge-cycle t gives beats in cycles t+1 .. t+L, and dma_done at t+L+1.
- For read bursts, dma_rvalid is high in cycles t+2 .. t+L+1.
- Maximum CPU stall caused by one burst: L cycles.

## Configuration
- DMEM_ARB_STARVE_EN
  - Defined: the starvation counter is present, and starve_hit can force a grant while the CPU is accessing memory.
  - Undefined: the counter is not built and starve_hit is tied to 0. DMA is granted only in IDLE cycles with no CPU access (strict CPU priority), so DMA may starve indefinitely.

## Test plan
- **Idle DMA write burst.** CPU idle; dma_req with dma_we=1, dma_addr=3, dma_len=4. Required: gnt at t; ack at t+1..t+4; mem_addr = 3,4,5,6 with mem_wr=1; done at t+5.
- **Wrap-around read burst.** dma_addr=30, dma_len=4, dma_we=0, memory preloaded. Required: mem_addr = 30,31,0,1; dma_rdata matches the preloaded words with rvalid at t+2..t+5.
- **CPU collision.** cpu_rd held high during a 3-beat burst. Required: cpu_stall=1 for exactly 3 cycles, then 0, and the CPU read is served in IDLE.
- **Starvation** (macro defined, STARVE_LIMIT=4). cpu_wr high continuously and dma_req high. Required: gnt on the 5th request cycle. With the macro undefined: no gnt while cpu_wr stays high.
- **Length clamp.** dma_len=0 gives exactly 1 beat; dma_len=15 gives exactly 8 beats.
- **Async reset mid-burst.** Assert rst low during beat 2. Required: all outputs 0 immediately; no dma_done; FSM in IDLE after release.
